// File: rtl/zap_wb_arb_pkg.sv
// Shared definitions for the two-master Wishbone arbiter.
package zap_wb_arb_pkg;

   // Arbiter FSM states
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      TMO  = 2'd2
   } arb_state_t;

   // Wishbone B4 cycle-type indicator codes
   localparam logic [2:0] CLASSIC = 3'b000;
   localparam logic [2:0] INCR    = 3'b010;
   localparam logic [2:0] EOB     = 3'b111;

   // Swap a one-hot two-bit grant to the other master
   function automatic logic [1:0] other_grant(input logic [1:0] g);
      return {g[0], g[1]};
   endfunction

endpackage

// File: rtl/zap_wb_watchdog.sv
// Bus watchdog: counts consecutive stalled strobe cycles and flags when the
// count has reached TIMEOUT-1. The flag is registered so the arbiter's
// next-state logic does not sit behind the counter's compare chain.
module zap_wb_watchdog
   import zap_wb_arb_pkg::*;
#(
   parameter int TIMEOUT = 255
) (
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic i_run,
   input  logic i_clear,
   output logic o_expire
);

   localparam int              CW    = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
   localparam logic            EN    = (TIMEOUT > 0);
   localparam logic [CW-1:0]   LIMIT = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;

   logic [CW-1:0] r_cnt;
   logic [CW-1:0] w_cnt_nxt;
   logic          r_at_lim;

   // Next count: clear has priority, otherwise advance while stalled
   always_comb begin
      w_cnt_nxt = r_cnt;
      if (i_clear) begin
         w_cnt_nxt = '0;
      end else if (i_run && EN) begin
         w_cnt_nxt = r_cnt + 1'b1;
      end
   end

   // Counter and registered "count is at TIMEOUT-1" flag
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_cnt    <= '0;
         r_at_lim <= EN && (LIMIT == '0);
      end else begin
         r_cnt    <= w_cnt_nxt;
         r_at_lim <= EN && (w_cnt_nxt == LIMIT);
      end
   end

   assign o_expire = r_at_lim;

endmodule

// File: rtl/zap_wb_arb2.sv
// Two-master round-robin Wishbone B4 arbiter with grant held for the whole
// CYC and a watchdog that terminates stalled strobes with ERR.
module zap_wb_arb2
   import zap_wb_arb_pkg::*;
#(
   parameter int TIMEOUT = 255
) (
   input  logic        i_clk,
   input  logic        i_rst_n,
   input  logic        i_m0_cyc,
   input  logic        i_m0_stb,
   input  logic        i_m0_we,
   input  logic [31:0] i_m0_adr,
   input  logic [31:0] i_m0_dat,
   input  logic [3:0]  i_m0_sel,
   input  logic [2:0]  i_m0_cti,
   output logic        o_m0_ack,
   output logic        o_m0_err,
   output logic [31:0] o_m0_dat,
   input  logic        i_m1_cyc,
   input  logic        i_m1_stb,
   input  logic        i_m1_we,
   input  logic [31:0] i_m1_adr,
   input  logic [31:0] i_m1_dat,
   input  logic [3:0]  i_m1_sel,
   input  logic [2:0]  i_m1_cti,
   output logic        o_m1_ack,
   output logic        o_m1_err,
   output logic [31:0] o_m1_dat,
   output logic        o_wb_cyc,
   output logic        o_wb_stb,
   output logic        o_wb_we,
   output logic [31:0] o_wb_adr,
   output logic [31:0] o_wb_dat,
   output logic [3:0]  o_wb_sel,
   output logic [2:0]  o_wb_cti,
   input  logic        i_wb_ack,
   input  logic        i_wb_err,
   input  logic [31:0] i_wb_dat,
   output logic [1:0]  o_grant,
   output logic        o_timeout_irq
);

   arb_state_t r_state, w_state_nxt;
   logic [1:0] r_grant, w_grant_nxt;
   logic       r_last,  w_last_nxt;   // index of the last-served master

   logic w_own_cyc;
   logic w_own_stb;
   logic w_oth_cyc;
   logic w_busy;
   logic w_tmo;
   logic w_run;
   logic w_clear;
   logic w_expire;

   assign w_busy = (r_state == BUSY);
   assign w_tmo  = (r_state == TMO);

   // Owner/other request lines and the owner-to-slave request mux
   always_comb begin
      w_own_cyc = 1'b0;
      w_own_stb = 1'b0;
      w_oth_cyc = 1'b0;
      o_wb_we   = 1'b0;
      o_wb_adr  = '0;
      o_wb_dat  = '0;
      o_wb_sel  = '0;
      o_wb_cti  = CLASSIC;
      if (r_grant[0]) begin
         w_own_cyc = i_m0_cyc;
         w_own_stb = i_m0_stb;
         w_oth_cyc = i_m1_cyc;
         o_wb_we   = i_m0_we;
         o_wb_adr  = i_m0_adr;
         o_wb_dat  = i_m0_dat;
         o_wb_sel  = i_m0_sel;
         o_wb_cti  = i_m0_cti;
      end else if (r_grant[1]) begin
         w_own_cyc = i_m1_cyc;
         w_own_stb = i_m1_stb;
         w_oth_cyc = i_m0_cyc;
         o_wb_we   = i_m1_we;
         o_wb_adr  = i_m1_adr;
         o_wb_dat  = i_m1_dat;
         o_wb_sel  = i_m1_sel;
         o_wb_cti  = i_m1_cti;
      end
   end

   // Slave cyc/stb only pass through while a transfer is live
   assign o_wb_cyc = w_busy & w_own_cyc;
   assign o_wb_stb = w_busy & w_own_stb;

   // Terminations route to the owner only; watchdog ERR replaces the slave's
   assign o_m0_ack      = w_busy & r_grant[0] & i_wb_ack;
   assign o_m1_ack      = w_busy & r_grant[1] & i_wb_ack;
   assign o_m0_err      = r_grant[0] & ((w_busy & i_wb_err) | w_tmo);
   assign o_m1_err      = r_grant[1] & ((w_busy & i_wb_err) | w_tmo);
   assign o_m0_dat      = i_wb_dat;
   assign o_m1_dat      = i_wb_dat;
   assign o_grant       = r_grant;
   assign o_timeout_irq = w_tmo;

   assign w_run   = w_busy & o_wb_stb & ~i_wb_ack & ~i_wb_err;
   assign w_clear = ~w_run | (w_grant_nxt != r_grant);

   zap_wb_watchdog #(
      .TIMEOUT (TIMEOUT)
   ) u_wdog (
      .i_clk    (i_clk),
      .i_rst_n  (i_rst_n),
      .i_run    (w_run),
      .i_clear  (w_clear),
      .o_expire (w_expire)
   );

   // Arbitration, hold, release/handoff and watchdog transitions
   always_comb begin
      w_state_nxt = r_state;
      w_grant_nxt = r_grant;
      w_last_nxt  = r_last;
      case (r_state)
         IDLE: begin
            if (i_m0_cyc && (!i_m1_cyc || r_last)) begin
               w_state_nxt = BUSY;
               w_grant_nxt = 2'b01;
               w_last_nxt  = 1'b0;
            end else if (i_m1_cyc) begin
               w_state_nxt = BUSY;
               w_grant_nxt = 2'b10;
               w_last_nxt  = 1'b1;
            end
         end
         BUSY, TMO: begin
            if (!w_own_cyc) begin
               if (w_oth_cyc) begin
                  w_state_nxt = BUSY;
                  w_grant_nxt = other_grant(r_grant);
                  w_last_nxt  = r_grant[0];
               end else begin
                  w_state_nxt = IDLE;
                  w_grant_nxt = 2'b00;
               end
            end else if (w_tmo) begin
               w_state_nxt = BUSY;
            end else if (w_run && w_expire) begin
               w_state_nxt = TMO;
            end
         end
         default: begin
            w_state_nxt = IDLE;
            w_grant_nxt = 2'b00;
         end
      endcase
   end

   // State, grant and round-robin pointer registers
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state <= IDLE;
         r_grant <= 2'b00;
         r_last  <= 1'b1;
      end else begin
         r_state <= w_state_nxt;
         r_grant <= w_grant_nxt;
         r_last  <= w_last_nxt;
      end
   end

endmodule

// File: tb/tb_zap_wb_arb2.sv
// Randomised plus directed bench for zap_wb_arb2 with a scoreboard queue of
// per-cycle expected outputs produced by a transaction-level model.
module tb_zap_wb_arb2;
   import zap_wb_arb_pkg::*;

   localparam int TMOUT = 8;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n;
   logic        m_cyc [2];
   logic        m_stb [2];
   logic        m_we  [2];
   logic [31:0] m_adr [2];
   logic [31:0] m_dat [2];
   logic [3:0]  m_sel [2];
   logic [2:0]  m_cti [2];
   logic        wb_ack, wb_err;
   logic [31:0] wb_rdat;

   logic        m0_ack, m0_err, m1_ack, m1_err;
   logic [31:0] m0_rdat, m1_rdat;
   logic        wb_cyc, wb_stb, wb_we;
   logic [31:0] wb_adr, wb_wdat;
   logic [3:0]  wb_sel;
   logic [2:0]  wb_cti;
   logic [1:0]  grant;
   logic        irq;

   zap_wb_arb2 #(.TIMEOUT(TMOUT)) dut (
      .i_clk(clk), .i_rst_n(rst_n),
      .i_m0_cyc(m_cyc[0]), .i_m0_stb(m_stb[0]), .i_m0_we(m_we[0]),
      .i_m0_adr(m_adr[0]), .i_m0_dat(m_dat[0]), .i_m0_sel(m_sel[0]), .i_m0_cti(m_cti[0]),
      .o_m0_ack(m0_ack), .o_m0_err(m0_err), .o_m0_dat(m0_rdat),
      .i_m1_cyc(m_cyc[1]), .i_m1_stb(m_stb[1]), .i_m1_we(m_we[1]),
      .i_m1_adr(m_adr[1]), .i_m1_dat(m_dat[1]), .i_m1_sel(m_sel[1]), .i_m1_cti(m_cti[1]),
      .o_m1_ack(m1_ack), .o_m1_err(m1_err), .o_m1_dat(m1_rdat),
      .o_wb_cyc(wb_cyc), .o_wb_stb(wb_stb), .o_wb_we(wb_we),
      .o_wb_adr(wb_adr), .o_wb_dat(wb_wdat), .o_wb_sel(wb_sel), .o_wb_cti(wb_cti),
      .i_wb_ack(wb_ack), .i_wb_err(wb_err), .i_wb_dat(wb_rdat),
      .o_grant(grant), .o_timeout_irq(irq)
   );

   typedef struct {
      logic [1:0]  grant;
      logic        cyc, stb, we;
      logic [31:0] adr, wdat, rdat;
      logic [3:0]  sel;
      logic [2:0]  cti;
      logic        ack0, ack1, err0, err1, irq;
      bit          chk_bus;
   } exp_t;

   exp_t sbq[$];
   int   total = 0;
   int   bad   = 0;

   // Reference model: who owns the bus, who was served last, how many
   // consecutive stalled strobe cycles, and whether this is the ERR cycle.
   int mo_owner;
   int mo_last;
   int mo_stall;
   bit mo_tmo;

   function automatic void model_reset();
      mo_owner = -1;
      mo_last  = 1;
      mo_stall = 0;
      mo_tmo   = 1'b0;
   endfunction

   function automatic void model_release();
      int o;
      o = 1 - mo_owner;
      if (m_cyc[o]) begin
         mo_owner = o;
         mo_last  = o;
      end else begin
         mo_owner = -1;
      end
      mo_stall = 0;
      mo_tmo   = 1'b0;
   endfunction

   function automatic void model_update();
      if (!rst_n) begin
         model_reset();
      end else if (mo_owner < 0) begin
         if (m_cyc[0] && m_cyc[1]) mo_owner = (mo_last == 0) ? 1 : 0;
         else if (m_cyc[0])        mo_owner = 0;
         else if (m_cyc[1])        mo_owner = 1;
         if (mo_owner >= 0) mo_last = mo_owner;
         mo_stall = 0;
      end else if (!m_cyc[mo_owner]) begin
         model_release();
      end else if (mo_tmo) begin
         mo_tmo   = 1'b0;
         mo_stall = 0;
      end else if (m_stb[mo_owner] && !wb_ack && !wb_err) begin
         mo_stall++;
         if (TMOUT > 0 && mo_stall == TMOUT) begin
            mo_tmo   = 1'b1;
            mo_stall = 0;
         end
      end else begin
         mo_stall = 0;
      end
   endfunction

   function automatic exp_t model_expect();
      exp_t e;
      int   o;
      e = '{grant:2'b00, cyc:1'b0, stb:1'b0, we:1'b0, adr:'0, wdat:'0, rdat:wb_rdat,
            sel:'0, cti:CLASSIC, ack0:1'b0, ack1:1'b0, err0:1'b0, err1:1'b0,
            irq:1'b0, chk_bus:1'b1};
      o = mo_owner;
      if (o >= 0) begin
         e.grant = (o == 0) ? 2'b01 : 2'b10;
         if (mo_tmo) begin
            e.chk_bus = 1'b0;
            e.irq     = 1'b1;
            if (o == 0) e.err0 = 1'b1; else e.err1 = 1'b1;
         end else begin
            e.cyc  = m_cyc[o];
            e.stb  = m_stb[o];
            e.we   = m_we[o];
            e.adr  = m_adr[o];
            e.wdat = m_dat[o];
            e.sel  = m_sel[o];
            e.cti  = m_cti[o];
            if (o == 0) begin e.ack0 = wb_ack; e.err0 = wb_err; end
            else        begin e.ack1 = wb_ack; e.err1 = wb_err; end
         end
      end
      return e;
   endfunction

   function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endfunction

   // Monitor: compare one expected snapshot per cycle on the falling edge
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (sbq.size() > 0) begin
            e = sbq.pop_front();
            chk("grant",  32'(grant),  32'(e.grant));
            chk("wb_cyc", 32'(wb_cyc), 32'(e.cyc));
            chk("wb_stb", 32'(wb_stb), 32'(e.stb));
            chk("m0_ack", 32'(m0_ack), 32'(e.ack0));
            chk("m1_ack", 32'(m1_ack), 32'(e.ack1));
            chk("m0_err", 32'(m0_err), 32'(e.err0));
            chk("m1_err", 32'(m1_err), 32'(e.err1));
            chk("irq",    32'(irq),    32'(e.irq));
            chk("m0_dat", m0_rdat, e.rdat);
            chk("m1_dat", m1_rdat, e.rdat);
            if (e.chk_bus) begin
               chk("wb_we",  32'(wb_we),  32'(e.we));
               chk("wb_adr", wb_adr,      e.adr);
               chk("wb_dat", wb_wdat,     e.wdat);
               chk("wb_sel", 32'(wb_sel), 32'(e.sel));
               chk("wb_cti", 32'(wb_cti), 32'(e.cti));
            end
         end
      end
   end

   task automatic set_m(input int i, input logic cyc, input logic stb,
                        input logic [31:0] adr, input logic [2:0] cti);
      m_cyc[i] = cyc;
      m_stb[i] = stb;
      m_adr[i] = adr;
      m_cti[i] = cti;
      m_we[i]  = 1'($urandom);
      m_dat[i] = $urandom;
      m_sel[i] = 4'($urandom);
   endtask

   // One bus cycle: record expectation for the current inputs, then advance
   task automatic step();
      wb_rdat = $urandom;
      if (!rst_n) model_reset();
      sbq.push_back(model_expect());
      @(posedge clk);
      model_update();
      #1;
   endtask

   initial begin
      bit stall_mode;
      rst_n = 1'b0;
      wb_ack = 1'b0; wb_err = 1'b0; wb_rdat = '0;
      set_m(0, 0, 0, 0, CLASSIC);
      set_m(1, 0, 0, 0, CLASSIC);
      model_reset();
      @(posedge clk); #1;

      // reset state
      step(); step();
      rst_n = 1'b1; step();

      // lone request, ack on the third strobe cycle
      set_m(0, 1, 1, 32'h1000, CLASSIC); step();
      step(); step();
      wb_ack = 1'b1; step();
      wb_ack = 1'b0; set_m(0, 0, 0, 0, CLASSIC); step(); step();

      // simultaneous request, handoff, next tie
      set_m(0, 1, 1, 32'h2000, CLASSIC); set_m(1, 1, 1, 32'h3000, CLASSIC); step();
      wb_ack = 1'b1; step();
      wb_ack = 1'b0; set_m(0, 0, 0, 0, CLASSIC); step();
      wb_ack = 1'b1; step();
      wb_ack = 1'b0; set_m(1, 0, 0, 0, CLASSIC); step();
      set_m(0, 1, 1, 32'h2100, CLASSIC); set_m(1, 1, 1, 32'h3100, CLASSIC); step();
      step();
      set_m(0, 0, 0, 0, CLASSIC); set_m(1, 0, 0, 0, CLASSIC); step(); step();

      // burst hold: m1 INCR x4 ending in EOB while m0 requests
      set_m(1, 1, 1, 32'h4000, INCR); step();
      set_m(0, 1, 1, 32'h5000, CLASSIC);
      for (int b = 0; b < 4; b++) begin
         m_adr[1] = 32'h4000 + 32'(4 * b);
         m_cti[1] = (b == 3) ? EOB : INCR;
         wb_ack = 1'b1; step();
      end
      wb_ack = 1'b0; set_m(1, 0, 0, 0, CLASSIC); step();
      wb_ack = 1'b1; step();
      wb_ack = 1'b0; set_m(0, 0, 0, 0, CLASSIC); step();

      // watchdog with retry under continuous cyc
      set_m(0, 1, 1, 32'h6000, CLASSIC);
      repeat (22) step();
      set_m(0, 0, 0, 0, CLASSIC); step(); step();

      // ack exactly on the last allowed stall cycle
      set_m(0, 1, 1, 32'h7000, CLASSIC); step();
      repeat (TMOUT - 1) step();
      wb_ack = 1'b1; step();
      wb_ack = 1'b0; repeat (3) step();
      set_m(0, 0, 0, 0, CLASSIC); step();

      // async reset during beat 2 of a burst
      set_m(1, 1, 1, 32'h8000, INCR); step();
      wb_ack = 1'b1; step();
      set_m(0, 1, 1, 32'h9000, CLASSIC); m_adr[1] = 32'h8004;
      rst_n = 1'b0; step(); step();
      rst_n = 1'b1; wb_ack = 1'b0; step();
      step(); step();
      set_m(0, 0, 0, 0, CLASSIC); set_m(1, 0, 0, 0, CLASSIC); step();

      // randomised traffic with periodic slave stall windows
      for (int c = 0; c < 3000; c++) begin
         stall_mode = ((c / 200) % 3) == 2;
         for (int i = 0; i < 2; i++) begin
            if (!m_cyc[i]) begin
               if ($urandom_range(0, 99) < 30)
                  set_m(i, 1, $urandom_range(0, 99) < 80, $urandom,
                        $urandom_range(0, 1) ? INCR : CLASSIC);
            end else if ($urandom_range(0, 99) < (stall_mode ? 3 : 15)) begin
               set_m(i, 0, 0, 0, CLASSIC);
            end else begin
               set_m(i, 1, $urandom_range(0, 99) < 85, $urandom,
                     $urandom_range(0, 1) ? INCR : EOB);
            end
         end
         wb_ack = !stall_mode && ($urandom_range(0, 99) < 50);
         wb_err = !stall_mode && !wb_ack && ($urandom_range(0, 99) < 5);
         rst_n  = $urandom_range(0, 999) >= 3;
         step();
      end

      rst_n = 1'b1; wb_ack = 1'b0; wb_err = 1'b0;
      set_m(0, 0, 0, 0, CLASSIC); set_m(1, 0, 0, 0, CLASSIC);
      step();
      @(negedge clk); @(negedge clk);
      chk("scoreboard_drained", 32'(sbq.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
